ptc_hold_capture: RTL and testbench
===================================

Name: ptc_hold_capture

Overview:
Receiving end of the PTC hold-control strobe. Consumes the hold pulse produced by the hold controller (the Ctrl_HLD strobe), synchronous to clk. On each pulse, it captures the phase code into a hold register and presents it on a valid/ready handshake. It also checks pulse width and pulse period so the FMDLL calibration loop can detect mis-timed hold windows.

Parameters:
W, 8, phase-code width
PW, 8, period counter / expected-period width
CW, 16, accepted-pulse counter width

Ports:
clk  input  1  system clock; all logic on rising edge
rst  input  1  asynchronous, active-high reset
en  input  1  capture enable; low forces IDLE
mode_m  input  1  M mode select: 1 = expected hold width 1 cycle, 0 = expected 2 cycles
hld_in  input  1  hold-control strobe, synchronous to clk
code_in  input  W  phase code sampled on hold edge
exp_period  input  PW  expected rise-to-rise period in clk cycles; 0 disables period check
held_code  output  W  captured phase code
held_valid  output  1  held_code valid
held_ready  input  1  downstream accepts held_code
width_err  output  1  one-cycle pulse: last hold pulse width wrong
period_err  output  1  one-cycle pulse: last period mismatched
ovf  output  1  sticky: capture dropped because held_valid was pending
period_cnt  output  PW  last measured period
pulse_cnt  output  CW  accepted capture count, wraps

Behaviour:
- Reset is asynchronous and active-high. Every register and output is 0 on reset: held_code, held_valid, width_err, period_err, ovf, period_cnt, pulse_cnt, hld_q, width/period counters, and state = IDLE. Reset asserted mid-operation aborts the operation immediately; the block re-arms only after rst falls and en = 1.
- hld_q is hld_in registered once.
  - rise = hld_in & ~hld_q.
  - fall = ~hld_in & hld_q.
- FSM states: IDLE, ARM, HIGH, LOW.
  - IDLE: en=1 -> ARM. In any state, en=0 -> IDLE next cycle; width/period counters clear; held_code, held_valid and ovf are kept.
  - ARM: rise -> HIGH. No period check on this first edge.
  - HIGH: counts hold width. fall -> LOW.
  - LOW: counts period. rise -> HIGH.
- Capture, in ARM or LOW on rise:
  - Latency 1: held_code = code_in as sampled in the rise cycle, visible the next cycle with held_valid = 1, and pulse_cnt increments (wraps at 2^CW).
  - If held_valid = 1 and held_ready = 0 in the rise cycle: the capture is dropped, held_code is unchanged, pulse_cnt is not incremented, and ovf is set. ovf clears only on rst.
  - If held_valid = 1 and held_ready = 1 in the rise cycle: the old value is consumed, the new value is loaded, and held_valid stays 1.
  - held_valid clears on held_valid & held_ready when there is no simultaneous capture.
- Width check:
  - The width counter resets to 1 on rise, increments each HIGH cycle and saturates at 3.
  - On fall, width_err pulses for 1 cycle (the cycle after fall) if width != (mode_m ? 1 : 2).
  - mode_m is sampled on rise.
- Period check:
  - The period counter resets to 1 on rise and increments every cycle until the next rise, saturating at 2^PW-1.
  - On each rise in LOW, period_cnt <= counter value, and period_err pulses 1 cycle if exp_period != 0 and counter != exp_period.
  - A saturated counter always mismatches when exp_period != 0.
- Hold pulse still high when en drops: no width check is performed.
- All outputs are registered. There are no combinational paths from inputs to outputs.

Test Plan:
- Reset/idle: assert rst mid-pulse with held_valid = 1 -> all outputs 0 immediately; after rst = 0, en = 1, the first hld pulse captures with no period_err.
- Nominal M=1: mode_m = 1, exp_period = 6, 1-cycle hld pulse every 6 cycles, code_in = 0x11, 0x22, 0x33, held_ready = 1 -> held_code 0x11/0x22/0x33 each one cycle after rise, period_cnt = 6, width_err = period_err = 0, pulse_cnt = 3.
- Width fault: mode_m = 0 with a 1-cycle pulse -> width_err single-cycle pulse; mode_m = 0 with a 3-cycle pulse -> width_err pulse (counter saturated at 3); a 2-cycle pulse -> no error.
- Period fault: exp_period = 6 with pulses spaced 6, 7, 6 -> exactly one period_err pulse, at the second rise; period_cnt = 7 then 6. exp_period = 0 -> no period_err ever.
- Backpressure: held_ready = 0, two pulses with codes 0xA5 and 0x5A -> held_code stays 0xA5, ovf = 1, pulse_cnt = 1. Then held_ready = 1 coinciding with a third rise (code 0x3C) -> held_code = 0x3C, held_valid stays 1.
- en drop: deassert en during HIGH -> state IDLE, no width_err. Re-enable -> ARM; first rise produces no period_err; held_code is retained throughout.

Source files
------------

// File: rtl/ptc_hold_capture.sv
// Receiving end of the PTC hold strobe: captures the phase code on each hold
// rise, presents it on a valid/ready handshake, and checks hold width and period.
module ptc_hold_capture #(
  parameter int W  = 8,
  parameter int PW = 8,
  parameter int CW = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic          mode_m,
  input  logic          hld_in,
  input  logic [W-1:0]  code_in,
  input  logic [PW-1:0] exp_period,
  output logic [W-1:0]  held_code,
  output logic          held_valid,
  input  logic          held_ready,
  output logic          width_err,
  output logic          period_err,
  output logic          ovf,
  output logic [PW-1:0] period_cnt,
  output logic [CW-1:0] pulse_cnt
);

  typedef enum logic [1:0] {IDLE, ARM, HIGH, LOW} state_t;

  localparam logic [PW-1:0] P_ONE = PW'(1);
  localparam logic [PW-1:0] P_MAX = '1;
  localparam logic [CW-1:0] C_ONE = CW'(1);

  state_t        state, state_nxt;
  logic          hld_q;
  logic          rise, fall;
  logic          cap;
  logic          mode_q;
  logic [1:0]    wcnt;
  logic [PW-1:0] pcnt;

  // Handshake: held_code transfers on a rising clk edge where held_valid and
  // held_ready are both high; held_code is stable while held_valid waits.
  assign rise = hld_in & ~hld_q;
  assign fall = ~hld_in & hld_q;
  assign cap  = en & rise & ((state == ARM) | (state == LOW));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (!en) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE:    state_nxt = ARM;
        ARM:     if (rise) state_nxt = HIGH;
        HIGH:    if (fall) state_nxt = LOW;
        LOW:     if (rise) state_nxt = HIGH;
        default: state_nxt = IDLE;
      endcase
    end
  end

  // Width/period measurement; both counters restart on every accepted rise.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hld_q      <= 1'b0;
      mode_q     <= 1'b0;
      wcnt       <= 2'd0;
      pcnt       <= '0;
      width_err  <= 1'b0;
      period_err <= 1'b0;
      period_cnt <= '0;
    end else begin
      hld_q      <= hld_in;
      width_err  <= 1'b0;
      period_err <= 1'b0;
      if (!en) begin
        wcnt <= 2'd0;
        pcnt <= '0;
      end else if (cap) begin
        wcnt   <= 2'd1;
        pcnt   <= P_ONE;
        mode_q <= mode_m;
        if (state == LOW) begin
          period_cnt <= pcnt;
          period_err <= (exp_period != '0) && (pcnt != exp_period);
        end
      end else if ((state == HIGH) || (state == LOW)) begin
        if (pcnt != P_MAX) pcnt <= pcnt + P_ONE;
        if (state == HIGH) begin
          if (fall)               width_err <= (wcnt != (mode_q ? 2'd1 : 2'd2));
          else if (wcnt != 2'd3)  wcnt <= wcnt + 2'd1;
        end
      end
    end
  end

  // A capture against a stalled, still-valid hold register is dropped.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      held_code  <= '0;
      held_valid <= 1'b0;
      ovf        <= 1'b0;
      pulse_cnt  <= '0;
    end else begin
      if (cap) begin
        if (held_valid && !held_ready) begin
          ovf <= 1'b1;
        end else begin
          held_code  <= code_in;
          held_valid <= 1'b1;
          pulse_cnt  <= pulse_cnt + C_ONE;
        end
      end else if (held_valid && held_ready) begin
        held_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_ptc_hold_capture.sv
// Bench for ptc_hold_capture: directed hold pulses, expected codes queued at
// drive time and popped when the handshake transfers a code.
module tb_ptc_hold_capture;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic        mode_m;
  logic        hld_in;
  logic [7:0]  code_in;
  logic [7:0]  exp_period;
  logic [7:0]  held_code;
  logic        held_valid;
  logic        held_ready;
  logic        width_err;
  logic        period_err;
  logic        ovf;
  logic [7:0]  period_cnt;
  logic [15:0] pulse_cnt;

  logic [7:0] exp_q[$];
  int vectors     = 0;
  int miscompares = 0;
  int werr_n      = 0;
  int perr_n      = 0;
  int n_cap       = 0;

  ptc_hold_capture #(.W(8), .PW(8), .CW(16)) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .mode_m     (mode_m),
    .hld_in     (hld_in),
    .code_in    (code_in),
    .exp_period (exp_period),
    .held_code  (held_code),
    .held_valid (held_valid),
    .held_ready (held_ready),
    .width_err  (width_err),
    .period_err (period_err),
    .ovf        (ovf),
    .period_cnt (period_cnt),
    .pulse_cnt  (pulse_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Drives one hold pulse of 'width' cycles followed by 'gap' low cycles.
  task automatic pulse(input logic [7:0] code, input int width, input int gap, input bit cap);
    code_in = code;
    hld_in  = 1'b1;
    if (cap) begin
      exp_q.push_back(code);
      n_cap++;
    end
    step(1);
    if (cap) begin
      check("lat_valid", held_valid, 1);
      check("lat_code", held_code, code);
    end
    step(width - 1);
    hld_in = 1'b0;
    step(gap);
  endtask

  // Scoreboard and error-pulse counters, sampled on the falling edge.
  always @(negedge clk) begin
    if (!rst) begin
      if (width_err)  werr_n++;
      if (period_err) perr_n++;
      if (held_valid && held_ready) begin
        if (exp_q.size() == 0) check("sb_unexpected", 1, 0);
        else                   check("sb_code", held_code, exp_q.pop_front());
      end
    end
  end

  initial begin
    int w0, p0, prev, gap;
    rst = 1'b1; en = 1'b0; mode_m = 1'b1; hld_in = 1'b0; code_in = '0;
    exp_period = 8'd6; held_ready = 1'b1;
    step(2);
    check("rst_code", held_code, 0);
    check("rst_valid", held_valid, 0);
    check("rst_ovf", ovf, 0);
    check("rst_pcnt", pulse_cnt, 0);
    check("rst_period", period_cnt, 0);
    rst = 1'b0; en = 1'b1;
    step(2);

    // Nominal M=1, period 6
    pulse(8'h11, 1, 5, 1);
    pulse(8'h22, 1, 5, 1);
    pulse(8'h33, 1, 5, 1);
    check("nom_pulse_cnt", pulse_cnt, 3);
    check("nom_period_cnt", period_cnt, 6);
    check("nom_werr", werr_n, 0);
    check("nom_perr", perr_n, 0);

    // Width faults with mode_m = 0
    mode_m = 1'b0;
    w0 = werr_n;
    pulse(8'($urandom_range(0, 255)), 1, 5, 1);
    check("w1_err", werr_n, w0 + 1);
    pulse(8'($urandom_range(0, 255)), 3, 3, 1);
    check("w3_err", werr_n, w0 + 2);
    pulse(8'($urandom_range(0, 255)), 2, 4, 1);
    check("w2_ok", werr_n, w0 + 2);
    check("w_perr", perr_n, 0);

    // Period fault: spacing 6, 7, 6
    mode_m = 1'b1;
    p0 = perr_n;
    pulse(8'h41, 1, 5, 1);
    pulse(8'h42, 1, 6, 1);
    pulse(8'h43, 1, 5, 1);
    check("p7_err", perr_n, p0 + 1);
    check("p7_cnt", period_cnt, 7);
    pulse(8'h44, 1, 5, 1);
    check("p6_err", perr_n, p0 + 1);
    check("p6_cnt", period_cnt, 6);

    // Period check disabled
    exp_period = 8'd0;
    p0 = perr_n;
    prev = 6;
    for (int i = 0; i < 4; i++) begin
      gap = $urandom_range(2, 9);
      pulse(8'($urandom_range(0, 255)), 1, gap, 1);
      check("p0_cnt", period_cnt, prev);
      prev = gap + 1;
    end
    check("p0_err", perr_n, p0);
    check("p0_pulse_cnt", pulse_cnt, n_cap);

    // Backpressure
    held_ready = 1'b0;
    pulse(8'hA5, 1, 5, 1);
    pulse(8'h5A, 1, 5, 0);
    check("bp_code", held_code, 8'hA5);
    check("bp_valid", held_valid, 1);
    check("bp_ovf", ovf, 1);
    check("bp_pulse_cnt", pulse_cnt, n_cap);
    held_ready = 1'b1;
    pulse(8'h3C, 1, 5, 1);
    check("bp_ovf_sticky", ovf, 1);
    check("bp_pulse_cnt2", pulse_cnt, n_cap);

    // en drop during HIGH
    mode_m = 1'b0; exp_period = 8'd6;
    w0 = werr_n;
    code_in = 8'hC3; hld_in = 1'b1;
    exp_q.push_back(8'hC3); n_cap++;
    step(2);
    en = 1'b0;
    step(1);
    hld_in = 1'b0;
    step(4);
    check("en_werr", werr_n, w0);
    check("en_code", held_code, 8'hC3);
    check("en_valid", held_valid, 0);
    en = 1'b1;
    step(2);
    p0 = perr_n;
    pulse(8'h69, 2, 5, 1);
    check("en_first_perr", perr_n, p0);
    check("en_first_pcnt", period_cnt, 6);
    check("en_first_werr", werr_n, w0);
    pulse(8'h96, 2, 4, 1);
    check("en_rearm_perr", perr_n, p0 + 1);
    check("en_rearm_pcnt", period_cnt, 7);

    // Reset mid-pulse with a pending capture
    held_ready = 1'b0; mode_m = 1'b1;
    code_in = 8'h87; hld_in = 1'b1;
    exp_q.push_back(8'h87); n_cap++;
    step(1);
    check("mr_valid_pre", held_valid, 1);
    rst = 1'b1;
    #1;
    check("mr_code", held_code, 0);
    check("mr_valid", held_valid, 0);
    check("mr_werr", width_err, 0);
    check("mr_perr", period_err, 0);
    check("mr_ovf", ovf, 0);
    check("mr_period", period_cnt, 0);
    check("mr_pulse_cnt", pulse_cnt, 0);
    exp_q.delete();
    n_cap = 0;
    hld_in = 1'b0;
    step(2);
    rst = 1'b0; held_ready = 1'b1;
    step(2);
    p0 = perr_n;
    pulse(8'h4B, 1, 5, 1);
    check("mr_first_perr", perr_n, p0);
    check("mr_first_pcnt", pulse_cnt, 1);
    check("mr_first_period", period_cnt, 0);

    for (int i = 0; i < 50 && exp_q.size() != 0; i++) step(1);
    check("sb_drain", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
